// File: rtl/mdu_ctrl_if.sv
// HI/LO op handshake between the E-stage issue logic (master) and the MDU controller (slave).
// An op transfers on a cycle where op_valid && op_ready && !flush and op_code != 7;
// the master holds op_valid/op_code/op_d2_zero stable until that cycle.
interface mdu_ctrl_if;
    logic       op_valid;
    logic [2:0] op_code;
    logic       op_d2_zero;
    logic       flush;
    logic       d_uses_hilo;
    logic       op_ready;
    logic       mdu_start;
    logic [2:0] mdu_mod;
    logic       stall_d;
    logic       busy;
    logic       done;
    logic       div_zero;

    modport master (
        output op_valid, op_code, op_d2_zero, flush, d_uses_hilo,
        input  op_ready, mdu_start, mdu_mod, stall_d, busy, done, div_zero
    );

    modport slave (
        input  op_valid, op_code, op_d2_zero, flush, d_uses_hilo,
        output op_ready, mdu_start, mdu_mod, stall_d, busy, done, div_zero
    );
endinterface

// File: rtl/mdu_ctrl.sv
// MDU sequencing controller: accepts HI/LO-writing ops, times mul/div latency,
// raises busy/done, stalls F/D on HI/LO hazards and keeps a sticky divide-by-zero flag.
module mdu_ctrl (
    input  logic            clk,
    input  logic            rst,
    mdu_ctrl_if.slave       bus,
    output logic [1:0]      dbg_state,
    output logic [3:0]      dbg_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MADD  = 3'd6;
    localparam logic [2:0] OP_RSVD  = 3'd7;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       div_zero_q, div_zero_d;

    logic       op_ready;
    logic       accept;
    logic       is_mul;
    logic       is_div;
    logic       mdu_start;
    logic [2:0] mdu_mod;
    logic       stall_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_zero_q <= div_zero_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_zero_d = div_zero_q;

        is_mul   = (bus.op_code == OP_MULT) || (bus.op_code == OP_MULTU) ||
                   (bus.op_code == OP_MADD);
        is_div   = (bus.op_code == OP_DIV) || (bus.op_code == OP_DIVU);
        op_ready = (state_q != RUN);
        // Reset beats a same-cycle accept so the aborted op never starts the MDU.
        accept   = bus.op_valid && op_ready && !bus.flush &&
                   (bus.op_code != OP_RSVD) && !rst;

        mdu_start = accept;
        mdu_mod   = accept ? bus.op_code : 3'd0;
        stall_d   = bus.d_uses_hilo && ((state_q == RUN) || (accept && (is_mul || is_div)));

        // The load value counts the accept cycle, so RUN ends when cnt reaches 2
        // and done lands exactly 5 (mul) or 10 (div) cycles after accept.
        unique case (state_q)
            RUN: begin
                if (cnt_q <= 4'd2) begin
                    state_d = DONE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (accept) begin
            if (is_mul) begin
                state_d = RUN;
                cnt_d   = 4'd5;
            end else if (is_div) begin
                state_d = RUN;
                cnt_d   = 4'd10;
                if (bus.op_d2_zero) div_zero_d = 1'b1;
            end else begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        end
    end

    assign bus.op_ready  = op_ready;
    assign bus.mdu_start = mdu_start;
    assign bus.mdu_mod   = mdu_mod;
    assign bus.stall_d   = stall_d;
    assign bus.busy      = (state_q == RUN);
    assign bus.done      = (state_q == DONE);
    assign bus.div_zero  = div_zero_q;

    assign dbg_state = state_q;
    assign dbg_cnt   = cnt_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: per-cycle vector table plus hand sequences for
// the long-latency div, back-to-back, and reset-abort cases.
module tb_mdu_ctrl;
  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  logic [3:0] dbg_cnt;
  int         n_checks;
  int         n_err;

  mdu_ctrl_if bus();

  mdu_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state),
    .dbg_cnt   (dbg_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic       valid;
    logic [2:0] code;
    logic       d2z;
    logic       flush;
    logic       hilo;
    logic       e_ready;
    logic       e_start;
    logic [2:0] e_mod;
    logic       e_stall;
    logic       e_busy;
    logic       e_done;
    logic       e_dz;
    logic [1:0] e_state;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string tag, input logic valid, input logic [2:0] code,
                     input logic d2z, input logic flush, input logic hilo,
                     input logic e_ready, input logic e_start, input logic [2:0] e_mod,
                     input logic e_stall, input logic e_busy, input logic e_done,
                     input logic e_dz, input logic [1:0] e_state);
    vec_t v;
    v.tag = tag; v.valid = valid; v.code = code; v.d2z = d2z; v.flush = flush;
    v.hilo = hilo; v.e_ready = e_ready; v.e_start = e_start; v.e_mod = e_mod;
    v.e_stall = e_stall; v.e_busy = e_busy; v.e_done = e_done; v.e_dz = e_dz;
    v.e_state = e_state;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic valid, input logic [2:0] code, input logic d2z,
                       input logic flush, input logic hilo);
    bus.op_valid = valid; bus.op_code = code; bus.op_d2_zero = d2z;
    bus.flush = flush; bus.d_uses_hilo = hilo;
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    rst      = 1'b1;
    drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    #1;
    do_reset();

    // tag, valid, code, d2z, flush, hilo | ready, start, mod, stall, busy, done, dz, state
    add("rst_idle",   0, 3'd0, 0, 0, 0, 1, 0, 3'd0, 0, 0, 0, 0, 2'd0);
    add("mult_c0",    1, 3'd0, 0, 0, 1, 1, 1, 3'd0, 1, 0, 0, 0, 2'd0);
    add("mult_c1",    0, 3'd0, 0, 0, 1, 0, 0, 3'd0, 1, 1, 0, 0, 2'd1);
    add("mult_c2",    0, 3'd0, 0, 0, 1, 0, 0, 3'd0, 1, 1, 0, 0, 2'd1);
    add("mult_c3",    0, 3'd0, 0, 0, 1, 0, 0, 3'd0, 1, 1, 0, 0, 2'd1);
    add("mult_c4",    0, 3'd0, 0, 0, 1, 0, 0, 3'd0, 1, 1, 0, 0, 2'd1);
    add("mult_c5",    0, 3'd0, 0, 0, 1, 1, 0, 3'd0, 0, 0, 1, 0, 2'd2);
    add("mult_c6",    0, 3'd0, 0, 0, 1, 1, 0, 3'd0, 0, 0, 0, 0, 2'd0);
    add("mthi_flush", 1, 3'd4, 0, 1, 1, 1, 0, 3'd0, 0, 0, 0, 0, 2'd0);
    add("mthi_acc",   1, 3'd4, 0, 0, 1, 1, 1, 3'd4, 0, 0, 0, 0, 2'd0);
    add("mthi_c1",    0, 3'd0, 0, 0, 0, 1, 0, 3'd0, 0, 0, 0, 0, 2'd0);
    add("mthi_c2",    0, 3'd0, 0, 0, 0, 1, 0, 3'd0, 0, 0, 0, 0, 2'd0);
    add("rsvd_op",    1, 3'd7, 0, 0, 1, 1, 0, 3'd0, 0, 0, 0, 0, 2'd0);
    add("rsvd_c1",    0, 3'd0, 0, 0, 0, 1, 0, 3'd0, 0, 0, 0, 0, 2'd0);
    add("mtlo_acc",   1, 3'd5, 0, 0, 0, 1, 1, 3'd5, 0, 0, 0, 0, 2'd0);
    add("mtlo_c1",    0, 3'd0, 0, 0, 0, 1, 0, 3'd0, 0, 0, 0, 0, 2'd0);

    foreach (vecs[i]) begin
      drive(vecs[i].valid, vecs[i].code, vecs[i].d2z, vecs[i].flush, vecs[i].hilo);
      #4;
      chk({vecs[i].tag, ".op_ready"},  8'(bus.op_ready),  8'(vecs[i].e_ready));
      chk({vecs[i].tag, ".mdu_start"}, 8'(bus.mdu_start), 8'(vecs[i].e_start));
      chk({vecs[i].tag, ".mdu_mod"},   8'(bus.mdu_mod),   8'(vecs[i].e_mod));
      chk({vecs[i].tag, ".stall_d"},   8'(bus.stall_d),   8'(vecs[i].e_stall));
      chk({vecs[i].tag, ".busy"},      8'(bus.busy),      8'(vecs[i].e_busy));
      chk({vecs[i].tag, ".done"},      8'(bus.done),      8'(vecs[i].e_done));
      chk({vecs[i].tag, ".div_zero"},  8'(bus.div_zero),  8'(vecs[i].e_dz));
      chk({vecs[i].tag, ".state"},     8'(dbg_state),     8'(vecs[i].e_state));
      if (i == 0) chk("rst_idle.cnt", 8'(dbg_cnt), 8'd0);
      next_cycle();
    end

    // divu by zero, second op held from cycle 3, accepted back-to-back in DONE (cycle 10)
    for (int c = 0; c <= 16; c++) begin
      if (c == 0)       drive(1'b1, 3'd3, 1'b1, 1'b0, 1'b0);
      else if (c < 3)   drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
      else if (c <= 10) drive(1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
      else              drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
      #4;
      chk($sformatf("divz.c%0d.div_zero", c), 8'(bus.div_zero), 8'(c >= 1));
      chk($sformatf("divz.c%0d.done", c), 8'(bus.done), 8'(c == 10 || c == 15));
      if (c == 0) chk("divz.c0.mdu_mod", 8'(bus.mdu_mod), 8'd3);
      if (c >= 1 && c <= 9) chk($sformatf("divz.c%0d.busy", c), 8'(bus.busy), 8'd1);
      if (c >= 3 && c <= 9) begin
        chk($sformatf("divz.c%0d.op_ready", c), 8'(bus.op_ready), 8'd0);
        chk($sformatf("divz.c%0d.mdu_start", c), 8'(bus.mdu_start), 8'd0);
      end
      if (c == 10) begin
        chk("divz.c10.op_ready", 8'(bus.op_ready), 8'd1);
        chk("divz.c10.mdu_start", 8'(bus.mdu_start), 8'd1);
      end
      next_cycle();
    end

    // mult then madd held valid: madd taken in the DONE cycle
    for (int c = 0; c <= 11; c++) begin
      if (c == 0)      drive(1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
      else if (c <= 5) drive(1'b1, 3'd6, 1'b0, 1'b0, 1'b0);
      else             drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
      #4;
      chk($sformatf("b2b.c%0d.done", c), 8'(bus.done), 8'(c == 5 || c == 10));
      chk($sformatf("b2b.c%0d.mdu_start", c), 8'(bus.mdu_start), 8'(c == 0 || c == 5));
      if (c == 5) chk("b2b.c5.mdu_mod", 8'(bus.mdu_mod), 8'd6);
      if (c == 8) chk("b2b.c8.busy", 8'(bus.busy), 8'd1);
      next_cycle();
    end

    // sticky div_zero clears only on reset
    chk("divz.sticky", 8'(bus.div_zero), 8'd1);
    do_reset();
    #4;
    chk("divz.cleared", 8'(bus.div_zero), 8'd0);
    next_cycle();

    // div aborted by reset at cycle 4, with a same-cycle op presented during reset
    for (int c = 0; c <= 16; c++) begin
      if (c == 0)      drive(1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
      else if (c == 4) drive(1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
      else             drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
      rst = (c == 4);
      #4;
      chk($sformatf("abort.c%0d.done", c), 8'(bus.done), 8'd0);
      if (c == 4) chk("abort.c4.mdu_start", 8'(bus.mdu_start), 8'd0);
      if (c == 5) begin
        chk("abort.c5.busy", 8'(bus.busy), 8'd0);
        chk("abort.c5.cnt", 8'(dbg_cnt), 8'd0);
        chk("abort.c5.op_ready", 8'(bus.op_ready), 8'd1);
        chk("abort.c5.state", 8'(dbg_state), 8'd0);
      end
      next_cycle();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
